// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Feature macro IMEM_LOADER_CHECKSUM_EN enables the trailing checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } ldr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } ldr_err_e;

  localparam int LEN_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Modulo-256 running sum; a frame is good when sum plus checksum byte is zero.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the byte source (master) and the loader (slave).
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and flags the byte that completes it.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [31:0] o_word_next,
  output logic        o_word_full
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_word;
  logic [31:0]      w_word_next;

  // New bytes enter at the top so that byte 0 ends up in [7:0] after four shifts.
  assign w_word_next = {i_byte, r_word[31:8]};
  assign o_word_next = w_word_next;
  assign o_word      = r_word;
  assign o_word_full = i_byte_en && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

  // Byte counter and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= 32'd0;
    end else if (i_byte_en) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_word <= w_word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> sequential 32-bit instruction memory writes from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum byte over the data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 20,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  imem_loader_if.slave      bs,
  output logic              o_iwr_en,
  output logic [ADDR_W-1:0] o_iaddr,
  output logic [31:0]       o_idata,
  output logic              o_core_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [15:0]       o_words_loaded
);

  ldr_state_e  r_state;
  ldr_state_e  w_next;
  logic [31:0] r_len;
  logic [15:0] r_word_idx;
  logic [15:0] r_words_loaded;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic        w_ready;
  logic        w_xfer;
  logic        w_pk_byte_en;
  logic        w_pk_full;
  logic [31:0] w_pk_word;
  logic [31:0] w_pk_word_next;
  logic        w_start_load;
  logic        w_err_set;
  logic [1:0]  w_err_code;

  assign w_ready      = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_xfer       = bs.byte_valid && w_ready;
  // abort beats a simultaneous byte: the packer never sees it.
  assign w_pk_byte_en = w_xfer && !i_abort && ((r_state == LEN) || (r_state == DATA));

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_load || i_abort),
    .i_byte_en   (w_pk_byte_en),
    .i_byte      (bs.byte_data),
    .o_word      (w_pk_word),
    .o_word_next (w_pk_word_next),
    .o_word_full (w_pk_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_csum_ok;
  assign w_csum_ok = (csum_add(r_sum, bs.byte_data) == 8'd0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus load-start and error-set strobes.
  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = ERR_NONE;
    if (i_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, ERR: begin
          if (i_start) begin
            w_next       = LEN;
            w_start_load = 1'b1;
          end else begin
            w_next = r_state;
          end
        end
        LEN: begin
          if (!w_pk_full) begin
            w_next = LEN;
          end else if (w_pk_word_next == 32'd0) begin
            w_next = DONE;
          end else if (w_pk_word_next > 32'(IMEM_DEPTH)) begin
            w_next     = ERR;
            w_err_set  = 1'b1;
            w_err_code = ERR_LEN;
          end else begin
            w_next = DATA;
          end
        end
        DATA: begin
          if (w_pk_full) begin
            w_next = WRITE;
          end else begin
            w_next = DATA;
          end
        end
        WRITE: begin
          if (({16'd0, r_word_idx} + 32'd1) < r_len) begin
            w_next = DATA;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = CSUM;
`else
            w_next = DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (!w_xfer) begin
            w_next = CSUM;
          end else if (w_csum_ok) begin
            w_next = DONE;
          end else begin
            w_next     = ERR;
            w_err_set  = 1'b1;
            w_err_code = ERR_CSUM;
          end
        end
`endif
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Length, word index, counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len          <= 32'd0;
      r_word_idx     <= 16'd0;
      r_words_loaded <= 16'd0;
      r_err          <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else if (w_start_load) begin
      r_len          <= 32'd0;
      r_word_idx     <= 16'd0;
      r_words_loaded <= 16'd0;
      r_err          <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else begin
      if ((r_state == LEN) && w_pk_full) begin
        r_len <= w_pk_word_next;
      end
      // The strobe fires whenever in WRITE, so the word is counted even under abort.
      if (r_state == WRITE) begin
        r_word_idx     <= r_word_idx + 16'd1;
        r_words_loaded <= r_words_loaded + 16'd1;
      end
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running sum of data bytes only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= 8'd0;
    end else if (w_start_load) begin
      r_sum <= 8'd0;
    end else if ((r_state == DATA) && w_pk_byte_en) begin
      r_sum <= csum_add(r_sum, bs.byte_data);
    end
  end
`endif

  assign bs.byte_ready    = w_ready;
  assign o_iwr_en         = (r_state == WRITE);
  assign o_iaddr          = ADDR_W'({r_word_idx, 2'b00});
  assign o_idata          = w_pk_word;
  assign o_core_hold      = (r_state != IDLE);
  assign o_done           = (r_state == DONE);
  assign o_err            = r_err;
  assign o_err_code       = r_err_code;
  assign o_words_loaded   = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, length errors, zero length, stalls, abort, reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        iwr_en;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        core_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  int          ready_viol = 0;

  imem_loader_if bs();

  imem_loader #(.IMEM_DEPTH(20), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .bs             (bs),
    .o_iwr_en       (iwr_en),
    .o_iaddr        (iaddr),
    .o_idata        (idata),
    .o_core_hold    (core_hold),
    .o_done         (done),
    .o_err          (err),
    .o_err_code     (err_code),
    .o_words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iwr_en) begin
      wr_addr.push_back(iaddr);
      wr_data.push_back(idata);
      if (bs.byte_ready) ready_viol++;
    end
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt   = 0;
    ready_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bs.byte_valid = 1'b0;
      @(negedge clk);
    end
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    n = 0;
    while (!bs.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", bs.byte_ready, 1'b1);
    @(negedge clk);
    bs.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], rnd ? bit'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic check_write(input logic [31:0] a, input logic [31:0] d);
    check_eq("iwr_en", iwr_en, 1'b1);
    check_eq("iaddr", iaddr, a);
    check_eq("idata", idata, d);
    check_eq("ready_in_write", bs.byte_ready, 1'b0);
  endtask

  // Two-word frame from the directed list; the checksum byte is -(0x13+0x93+0x10) = 0x4A.
  task automatic load_two(input bit rnd);
    clear_mon();
    pulse_start();
    check_eq("hold_after_start", core_hold, 1'b1);
    check_eq("err_cleared", err, 1'b0);
    check_eq("code_cleared", err_code, 2'd0);
    send_word(32'd2, rnd);
    send_word(32'h0000_0013, rnd);
    check_write(32'h0, 32'h0000_0013);
    send_word(32'h0010_0093, rnd);
    check_write(32'h4, 32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h4A, 1'b0);
`else
    @(negedge clk);
`endif
    check_eq("done_pulse", done, 1'b1);
    check_eq("words_loaded", words_loaded, 16'd2);
    @(negedge clk);
    check_eq("done_low", done, 1'b0);
    check_eq("hold_released", core_hold, 1'b0);
    #1;
    check_eq("wr_count", wr_addr.size(), 2);
    check_eq("wr0_addr", wr_addr[0], 32'h0);
    check_eq("wr0_data", wr_data[0], 32'h0000_0013);
    check_eq("wr1_addr", wr_addr[1], 32'h4);
    check_eq("wr1_data", wr_data[1], 32'h0010_0093);
    check_eq("done_count", done_cnt, 1);
    check_eq("ready_viol", ready_viol, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_iwr"}, iwr_en, 1'b0);
    check_eq({tag, "_iaddr"}, iaddr, 32'h0);
    check_eq({tag, "_idata"}, idata, 32'h0);
    check_eq({tag, "_hold"}, core_hold, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_code"}, err_code, 2'd0);
    check_eq({tag, "_wl"}, words_loaded, 16'd0);
    check_eq({tag, "_ready"}, bs.byte_ready, 1'b0);
  endtask

  initial begin
    bs.byte_valid = 1'b0;
    bs.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load
    load_two(1'b0);

    // Length overflow, then recovery
    clear_mon();
    pulse_start();
    send_word(32'h0000_0015, 1'b0);
    check_eq("len_err", err, 1'b1);
    check_eq("len_code", err_code, 2'd1);
    check_eq("err_hold", core_hold, 1'b1);
    check_eq("err_ready", bs.byte_ready, 1'b0);
    @(negedge clk);
    check_eq("err_sticky", err, 1'b1);
    #1;
    check_eq("len_err_wr", wr_addr.size(), 0);
    check_eq("len_err_done", done_cnt, 0);
    load_two(1'b0);

    // Zero length
    clear_mon();
    pulse_start();
    send_word(32'd0, 1'b0);
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_wl", words_loaded, 16'd0);
    @(negedge clk);
    check_eq("zero_idle", core_hold, 1'b0);
    #1;
    check_eq("zero_wr", wr_addr.size(), 0);

    // Stalling byte source
    load_two(1'b1);

    // Abort after six data bytes; a stray start and the abort-cycle byte are ignored
    clear_mon();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    check_eq("start_ignored", bs.byte_ready, 1'b1);
    abort = 1'b1;
    bs.byte_valid = 1'b1;
    bs.byte_data  = 8'h10;
    @(negedge clk);
    abort = 1'b0;
    bs.byte_valid = 1'b0;
    check_eq("abort_idle", core_hold, 1'b0);
    check_eq("abort_wl", words_loaded, 16'd1);
    check_eq("abort_err", err, 1'b0);
    #1;
    check_eq("abort_wr", wr_addr.size(), 1);
    check_eq("abort_done", done_cnt, 0);
    load_two(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum
    clear_mon();
    pulse_start();
    send_word(32'd2, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("csum_err", err, 1'b1);
    check_eq("csum_code", err_code, 2'd2);
    check_eq("csum_done", done, 1'b0);
    #1;
    check_eq("csum_wr", wr_addr.size(), 2);
    @(negedge clk);
    load_two(1'b0);
`endif

    // Reset mid-DATA
    pulse_start();
    send_word(32'd2, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
